uart_tx_engine: RTL

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_tx_engine.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode constants,
// used by both the transmit engine and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [8:0] word, input logic mode);
    return (^word) ^ mode;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period. Clearing restarts the period from zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, LSB-first data, optional parity and
// 1 or 2 stop bits, with back-to-back acceptance in the final stop cycle.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  uart_state_e          state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 baud_clear_s;
  logic                 baud_tick_s;
  logic                 last_cycle_s;
  logic                 accept_s;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear_s),
    .tick (baud_tick_s)
  );

  assign last_cycle_s = (state_q == STOP) && baud_tick_s && (bit_cnt_q == STOP_LAST);
  assign tx_ready     = (state_q == IDLE) || last_cycle_s;
  assign tx_done      = last_cycle_s;
  assign tx_busy      = (state_q != IDLE);
  assign tx           = tx_q;
  assign accept_s     = tx_start && tx_ready;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    baud_clear_s = 1'b0;
    case (state_q)
      IDLE: begin
        baud_clear_s = 1'b1;
        if (accept_s) begin
          state_d   = START;
          shift_d   = tx_data;
          parity_d  = calc_parity(9'(tx_data), PAR_MODE);
          bit_cnt_d = {BIT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_tick_s) begin
          state_d      = DATA;
          bit_cnt_d    = {BIT_W{1'b0}};
          baud_clear_s = 1'b1;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (baud_tick_s) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d      = (PARITY_EN != 0) ? PARITY : STOP;
            bit_cnt_d    = {BIT_W{1'b0}};
            baud_clear_s = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (baud_tick_s) begin
          state_d      = STOP;
          bit_cnt_d    = {BIT_W{1'b0}};
          baud_clear_s = 1'b1;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        // bit_cnt_q doubles as the stop-bit index here
        if (last_cycle_s) begin
          baud_clear_s = 1'b1;
          bit_cnt_d    = {BIT_W{1'b0}};
          if (accept_s) begin
            state_d  = START;
            shift_d  = tx_data;
            parity_d = calc_parity(9'(tx_data), PAR_MODE);
          end else begin
            state_d = IDLE;
          end
        end else if (baud_tick_s) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d      = IDLE;
        baud_clear_s = 1'b1;
      end
    endcase
  end

  // Line level is computed from the next state so tx stays a clean register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= {BIT_W{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

endmodule
